display_mux_4dig: RTL and testbench
===================================

# display_mux_4dig

- Four-digit, time-multiplexed, common-anode seven-segment display driver.
- Sits directly downstream of the 120 Hz prescaler and uses its one-cycle `o_clk_120Hz` pulse as the digit-advance tick.
- Each tick selects the next digit, decodes its hex nibble to segments and drives the anodes.
- Displayed data is captured once per frame to prevent tearing; a short anode-off gap after each digit change suppresses ghosting.

## Interface

Parameters:
- `BLANK` — default 4 — number of clock cycles all anodes stay off after each tick. Legal range 0..255.

Ports:
- `i_clk` — in, 1 — system clock.
- `i_reset` — in, 1 — reset, asynchronous, active-low.
- `i_tick` — in, 1 — digit-advance strobe, one cycle wide (the prescaler's 120 Hz pulse).
- `i_data` — in, 16 — four hex nibbles; `[3:0]` is digit 0 (rightmost) and `[15:12]` is digit 3 (leftmost).
- `i_dp` — in, 4 — decimal point enable per digit, active-high; bit n belongs to digit n.
- `i_lzb` — in, 1 — leading-zero blanking enable.
- `o_an` — out, 4 — anode enables, active-low; bit n drives digit n.
- `o_seg` — out, 7 — segments `{g,f,e,d,c,b,a}`, active-low.
- `o_dp` — out, 1 — decimal point segment, active-low.
- `o_frame` — out, 1 — one-cycle pulse marking each shadow reload (start of frame).

## Operation

Reset (`i_reset`=0, asynchronous):
- `o_an`=4'b1111, `o_seg`=7'b1111111, `o_dp`=1, `o_frame`=0.
- Digit index = 0, shadow data/dp/lzb = 0, blank counter = 0, `started`=0.
- The display stays dark until the first tick.

States:
- IDLE: entered only by reset; display dark.
- BLANK: anodes off, segments already updated.
- ON: the selected anode is enabled.

Tick handling, evaluated on the edge where `i_tick`=1:
- If `started`=0, or the index is 3:
  - index ← 0.
  - Shadow ← `{i_data, i_dp, i_lzb}`.
  - `o_frame` ← 1; `started` ← 1.
  - Segments for digit 0 are decoded from `i_data[3:0]` directly in the same edge.
- Otherwise, index ← index+1 and the decode uses the shadow.
- `o_an` ← 4'b1111 and the blank counter ← `BLANK`; go to BLANK.
- If `BLANK`=0, go straight to ON: `o_an` ← `~(4'b0001 << new index)` in the same edge.

BLANK state:
- Each cycle without a tick decrements the counter.
- When the counter is 1 and decrements, enable `o_an` for the current index and go to ON.
- Net effect: the anode turns on exactly `BLANK` cycles after the tick edge.

ON state: hold all outputs until the next tick.

Tick during BLANK: the tick is handled normally (index advances, counter reloads). No tick is ever dropped.

Decode (standard hex, active-low):
- 0 = 1000000
- 1 = 1111001
- 2 = 0100100
- 3 = 0110000
- 4 = 0011001
- 5 = 0010010
- 6 = 0000010
- 7 = 1111000
- 8 = 0000000
- 9 = 0010000
- A = 0001000
- b = 0000011
- C = 1000110
- d = 0100001
- E = 0000110
- F = 0001110

Leading-zero blanking (when shadow `lzb`=1):
- Digit n (n=3..1) is blanked (`o_seg`=7'b1111111) if the nibble of digit n and every more-significant nibble are zero.
- Digit 0 is never blanked.
- `o_dp` = ~shadow `dp[n]` regardless of blanking.

Only the shadow feeds the display, with one exception: the frame-start edge decodes digit 0 from `i_data`. Changes to `i_data`, `i_dp` or `i_lzb` mid-frame have no visible effect until the next frame.

## Timing

- All outputs are registered.
- Tick at edge T: `o_seg`, `o_dp`, `o_frame` and the anodes-off state become valid after T. The anode turns on after edge T+`BLANK`.
- `o_frame` is high for exactly one cycle following the frame-start edge.
- Frame = 4 ticks; at 120 Hz this gives a 30 Hz refresh per digit.
- Reset asserted mid-frame forces the reset values immediately. After release, the first tick behaves as frame start.
- `i_tick` held high for N cycles counts as N ticks (not filtered).

## Test plan

1. Reset, then no tick for 100 cycles → `o_an`=1111, `o_seg`=1111111, `o_dp`=1, `o_frame`=0 throughout.
2. `i_data`=16'h12AF, `i_dp`=4'b0100, `BLANK`=4, four ticks 20 cycles apart →
   - Digit 0 shows `o_seg`=0001110.
   - Digit 1: 0001000.
   - Digit 2: 0100100 with `o_dp`=0.
   - Digit 3: 1111001.
   - Each anode goes low exactly 4 cycles after its tick; `o_frame` pulses only on the first tick.
3. `i_data`=16'h0040, `i_lzb`=1 → digits 3 and 2 blanked; digit 1 = 0011001; digit 0 = 1000000.
4. Change `i_data` from 16'h1111 to 16'h8888 between tick 2 and tick 3 → digits 2 and 3 still show 1; the next frame shows 8 (0000000).
5. Tick arriving 2 cycles after the previous tick with `BLANK`=4 → index advances, the anode stays off, and it turns on 4 cycles after the second tick.
6. Assert `i_reset` while digit 2 is ON → all outputs return to reset values asynchronously. The first tick after release restarts at digit 0 with an `o_frame` pulse.

Source files
------------

// File: rtl/display_mux_4dig.sv
// -----------------------------------------------------------------------------
// display_mux_4dig
//   Four-digit, time-multiplexed, common-anode seven-segment display driver.
//   Each i_tick advances to the next digit, decodes its hex nibble and, after
//   BLANK clock cycles with every anode off (ghosting suppression), enables
//   that digit's anode. Display data is captured into a shadow register once
//   per frame (at digit 0) so a frame never mixes old and new values.
//
// Parameters
//   BLANK    : cycles all anodes stay off after each tick (0..255)
//
// Ports
//   i_clk    : system clock
//   i_reset  : asynchronous reset, active-low
//   i_tick   : one-cycle digit-advance strobe
//   i_data   : four hex nibbles, [3:0] = digit 0 (rightmost)
//   i_dp     : decimal point enables, bit n = digit n, active-high
//   i_lzb    : leading-zero blanking enable
//   o_an     : anode enables, active-low, bit n = digit n
//   o_seg    : segments {g,f,e,d,c,b,a}, active-low
//   o_dp     : decimal point segment, active-low
//   o_frame  : one-cycle pulse on each shadow reload (start of frame)
// -----------------------------------------------------------------------------
module display_mux_4dig #(
  parameter int BLANK = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_tick,
  input  logic [15:0] i_data,
  input  logic [3:0]  i_dp,
  input  logic        i_lzb,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;

  localparam logic [7:0] BLANK_CNT = 8'(BLANK);

  // Hex to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // State and shadow registers
  logic [1:0]  state_q,   state_d;
  logic [1:0]  idx_q,     idx_d;
  logic        started_q, started_d;
  logic [7:0]  cnt_q,     cnt_d;
  logic [15:0] data_q,    data_d;
  logic [3:0]  dp_sh_q,   dp_sh_d;
  logic        lzb_q,     lzb_d;
  logic [3:0]  an_q,      an_d;
  logic [6:0]  seg_q,     seg_d;
  logic        dp_q,      dp_d;
  logic        frame_q,   frame_d;

  // Decode helpers
  logic        frame_start;
  logic [1:0]  new_idx;
  logic [3:0]  lz;       // lz[n]: digit n and all more-significant nibbles are zero
  logic [3:0]  nib;
  logic        blank_dig;
  logic        dp_bit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    frame_start = i_tick && (!started_q || (idx_q == 2'd3));
    new_idx     = frame_start ? 2'd0 : idx_q + 2'd1;

    lz[3] = (data_q[15:12] == 4'h0);
    lz[2] = lz[3] && (data_q[11:8] == 4'h0);
    lz[1] = lz[2] && (data_q[7:4]  == 4'h0);
    lz[0] = 1'b0;   // digit 0 is never blanked

    // The frame-start edge decodes digit 0 straight from the input, since the
    // shadow only receives that value on this same edge.
    if (frame_start) begin
      nib       = i_data[3:0];
      blank_dig = 1'b0;
      dp_bit    = i_dp[0];
    end else begin
      nib       = data_q[{new_idx, 2'b00} +: 4];
      blank_dig = lzb_q && lz[new_idx];
      dp_bit    = dp_sh_q[new_idx];
    end

    state_d   = state_q;
    idx_d     = idx_q;
    started_d = started_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    dp_sh_d   = dp_sh_q;
    lzb_d     = lzb_q;
    an_d      = an_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    frame_d   = 1'b0;

    if (i_tick) begin
      // A tick is honoured in every state, including mid-blank.
      idx_d   = new_idx;
      seg_d   = blank_dig ? 7'b1111111 : hex_to_seg(nib);
      dp_d    = ~dp_bit;
      frame_d = frame_start;
      if (frame_start) begin
        data_d    = i_data;
        dp_sh_d   = i_dp;
        lzb_d     = i_lzb;
        started_d = 1'b1;
      end
      if (BLANK == 0) begin
        an_d    = ~(4'b0001 << new_idx);
        cnt_d   = 8'd0;
        state_d = S_ON;
      end else begin
        an_d    = 4'b1111;
        cnt_d   = BLANK_CNT;
        state_d = S_BLANK;
      end
    end else if (state_q == S_BLANK) begin
      cnt_d = cnt_q - 8'd1;
      // Counter reaching 1 here means this edge is BLANK cycles after the tick.
      if (cnt_q == 8'd1) begin
        an_d    = ~(4'b0001 << idx_q);
        state_d = S_ON;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      // NOTE: the shadow is an ordinary register bank, not a RAM, so it is
      // reset along with the control state.
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      started_q <= 1'b0;
      cnt_q     <= 8'd0;
      data_q    <= 16'h0000;
      dp_sh_q   <= 4'h0;
      lzb_q     <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      dp_sh_q   <= dp_sh_d;
      lzb_q     <= lzb_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_dp    = dp_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_display_mux_4dig.sv
// -----------------------------------------------------------------------------
// tb_display_mux_4dig
//   Scoreboard bench for display_mux_4dig. A reference model predicts the
//   digit shown by each tick and pushes it to a queue; the entry is popped and
//   compared when the DUT outputs become valid after the tick edge.
// -----------------------------------------------------------------------------
module tb_display_mux_4dig;

  localparam int BLANK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        lzb;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_out;
  logic        frame;

  display_mux_4dig #(.BLANK(BLANK)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .i_tick  (tick),
    .i_data  (data),
    .i_dp    (dp_in),
    .i_lzb   (lzb),
    .o_an    (an),
    .o_seg   (seg),
    .o_dp    (dp_out),
    .o_frame (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic       frame;
    logic [3:0] an_on;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit         m_started;
  int         m_idx;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  bit          m_lzb;

  // Currently displayed values, for hold and anode-on checks
  logic [3:0] cur_an;
  logic [6:0] cur_seg;
  logic       cur_dp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] tab [16];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tab[v];
  endfunction

  // Predict the digit selected by a tick with the current inputs.
  task automatic model_tick();
    exp_t e;
    logic [15:0] upper;
    logic [3:0]  v;
    e.frame = 1'b0;
    if (!m_started || m_idx == 3) begin
      m_idx     = 0;
      m_data    = data;
      m_dp      = dp_in;
      m_lzb     = lzb;
      m_started = 1;
      e.frame   = 1'b1;
    end else begin
      m_idx++;
    end
    v     = 4'((m_data >> (4 * m_idx)) & 16'hF);
    upper = m_data >> (4 * m_idx);
    if (m_lzb && m_idx != 0 && upper == 16'h0) e.seg = 7'b1111111;
    else                                       e.seg = seg_of(v);
    e.dp    = ~m_dp[m_idx];
    e.an_on = 4'b1111 & ~(4'b0001 << m_idx);
    sb.push_back(e);
  endtask

  // One-cycle tick; outputs are checked at the following negedge.
  task automatic send_tick(input string tag);
    exp_t e;
    @(negedge clk);
    tick = 1'b1;
    model_tick();
    @(negedge clk);
    tick = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_seg"},   32'(seg),    32'(e.seg));
      check({tag, "_dp"},    32'(dp_out), 32'(e.dp));
      check({tag, "_frame"}, 32'(frame),  32'(e.frame));
      check({tag, "_an_off"}, 32'(an),    32'hF);
      cur_an  = e.an_on;
      cur_seg = e.seg;
      cur_dp  = e.dp;
    end
  endtask

  // Called right after send_tick: anodes stay off through edge T+BLANK-1,
  // then the selected anode is on after edge T+BLANK.
  task automatic wait_on(input string tag);
    for (int k = 1; k < BLANK; k++) begin
      @(negedge clk);
      check({tag, "_gap"}, {27'd0, an, frame}, {27'd0, 4'hF, 1'b0});
    end
    @(negedge clk);
    check({tag, "_an_on"}, 32'(an), 32'(cur_an));
  endtask

  task automatic hold(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check({tag, "_hold"}, {20'd0, an, seg, dp_out}, {20'd0, cur_an, cur_seg, cur_dp});
    end
  endtask

  // Tick, wait for anode, hold until 20 cycles after the tick.
  task automatic digit(input string tag);
    send_tick(tag);
    wait_on(tag);
    hold(tag, 20 - BLANK - 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    data  = 16'h0000;
    dp_in = 4'h0;
    lzb   = 1'b0;
    m_started = 0;
    m_idx = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: dark with no ticks
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_dark", {19'd0, an, seg, dp_out, frame}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    end

    // 2: 12AF with decimal point on digit 2
    data  = 16'h12AF;
    dp_in = 4'b0100;
    digit("f2_d0");
    digit("f2_d1");
    digit("f2_d2");
    digit("f2_d3");

    // 3: leading-zero blanking of 0040
    data  = 16'h0040;
    dp_in = 4'b0000;
    lzb   = 1'b1;
    digit("lzb_d0");
    digit("lzb_d1");
    digit("lzb_d2");
    digit("lzb_d3");

    // 4: mid-frame data change is deferred to the next frame
    data = 16'h1111;
    lzb  = 1'b0;
    digit("tear_d0");
    digit("tear_d1");
    data = 16'h8888;
    digit("tear_d2");
    digit("tear_d3");
    digit("next_d0");
    digit("next_d1");
    digit("next_d2");
    digit("next_d3");

    // 5: second tick 2 cycles into the blank gap
    send_tick("fast_a");
    send_tick("fast_b");
    wait_on("fast_b");
    hold("fast_b", 5);

    // 6: asynchronous reset while digit 2 is on
    send_tick("rst_d2");
    wait_on("rst_d2");
    hold("rst_d2", 3);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {19'd0, an, seg, dp_out, frame}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    check("in_reset", {19'd0, an, seg, dp_out, frame}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    rst_n = 1'b1;
    m_started = 0;
    m_idx = 0;
    data  = 16'h5A3C;
    dp_in = 4'b0001;
    digit("post_d0");
    digit("post_d1");

    if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
